// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and message-schedule helpers.
package sha256_pkg;

    typedef enum logic [2:0] {
        LOAD,
        RSTC,
        PRIME,
        RUN,
        UPD,
        DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// Sixteen-word message schedule window: loaded word by word, then shifted
// once per round while the next schedule word is expanded into the top slot.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        load_en,
    input  logic [3:0]  load_idx,
    input  logic [31:0] load_data,
    input  logic        shift_en,
    output logic [31:0] w0
);

    logic [31:0] win [16];

    // Load a chunk word into its slot, or advance the schedule by one round.
    always_ff @(posedge clk) begin
        if (load_en) begin
            win[load_idx] <= load_data;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
        end
    end

    assign w0 = win[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Chunk sequencer for the SHA-256 compressor: buffers sixteen words, then
// runs the compressor for 64 rounds and issues the hash-accumulate strobe.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        s_first,
    output logic        s_ready,
    output logic        cmp_rst_n,
    output logic        cmp_enable,
    output logic        cmp_update,
    output logic [31:0] cmp_w,
    output logic [31:0] cmp_k,
    output logic        busy,
    output logic        done
);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  wcnt_q;
    logic [5:0]  round_q;
    logic        first_q;
    logic        accept;
    logic [31:0] sched_w0;

    assign accept = s_valid && (state_q == LOAD);

    // Next-state selection for the chunk sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && (wcnt_q == 4'd15)) state_d = first_q ? RSTC : PRIME;
            RSTC:    state_d = PRIME;
            PRIME:   state_d = RUN;
            RUN:     if (round_q == 6'd63) state_d = UPD;
            UPD:     state_d = DONE;
            DONE:    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // State, counters, first-chunk flag and registered compressor controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            wcnt_q     <= '0;
            round_q    <= '0;
            first_q    <= 1'b0;
            cmp_rst_n  <= 1'b0;
            cmp_enable <= 1'b0;
            cmp_update <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wcnt_q <= wcnt_q + 4'd1;
                if (wcnt_q == 4'd0) first_q <= s_first;
            end
            if (state_q == PRIME) begin
                round_q <= '0;
            end else if (state_q == RUN) begin
                round_q <= round_q + 6'd1;
            end
            // Controls follow the upcoming state so they are aligned with it.
            cmp_rst_n  <= (state_d != RSTC);
            cmp_enable <= (state_d == RUN) || (state_d == UPD);
            cmp_update <= (state_d == UPD);
        end
    end

    sha256_msg_sched u_sched (
        .clk       (clk),
        .load_en   (accept),
        .load_idx  (wcnt_q),
        .load_data (s_data),
        .shift_en  (state_q == RUN),
        .w0        (sched_w0)
    );

    assign s_ready = (state_q == LOAD);
    assign busy    = (state_q != LOAD);
    assign done    = (state_q == DONE);
    assign cmp_w   = (state_q == RUN) ? sched_w0 : '0;
    assign cmp_k   = (state_q == UPD) ? '0 : K[round_q];

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl with a behavioural compressor attached to its
// control outputs; digests, latencies and per-round W/K values are checked.
module tb_sha256_round_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_first;
    logic        s_ready;
    logic        cmp_rst_n;
    logic        cmp_enable;
    logic        cmp_update;
    logic [31:0] cmp_w;
    logic [31:0] cmp_k;
    logic        busy;
    logic        done;

    sha256_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_first    (s_first),
        .s_ready    (s_ready),
        .cmp_rst_n  (cmp_rst_n),
        .cmp_enable (cmp_enable),
        .cmp_update (cmp_update),
        .cmp_w      (cmp_w),
        .cmp_k      (cmp_k),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural compressor ----------------
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] t1f(input logic [31:0] e, f, g, h, k, w);
        return h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    endfunction

    function automatic logic [31:0] t2f(input logic [31:0] a, b, c);
        return (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    endfunction

    logic [31:0] hs [8];
    logic [31:0] v  [8];
    logic        crst_n;
    assign crst_n = cmp_rst_n & ~rst;

    always @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            for (int i = 0; i < 8; i++) begin
                hs[i] <= IV[i];
                v[i]  <= IV[i];
            end
        end else if (!cmp_enable) begin
            for (int i = 0; i < 8; i++) v[i] <= hs[i];
        end else if (cmp_update) begin
            for (int i = 0; i < 8; i++) hs[i] <= hs[i] + v[i];
        end else begin
            v[0] <= t1f(v[4], v[5], v[6], v[7], cmp_k, cmp_w) + t2f(v[0], v[1], v[2]);
            v[1] <= v[0];
            v[2] <= v[1];
            v[3] <= v[2];
            v[4] <= v[3] + t1f(v[4], v[5], v[6], v[7], cmp_k, cmp_w);
            v[5] <= v[4];
            v[6] <= v[5];
            v[7] <= v[6];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        bit          chk_hash;
        logic [31:0] h0;
        logic [31:0] h7;
        int          lat;
    } exp_t;

    exp_t sb [$];

    task automatic push_exp(input string nm, input bit ch, input logic [31:0] h0,
                            input logic [31:0] h7, input int lat);
        exp_t e;
        e.name = nm; e.chk_hash = ch; e.h0 = h0; e.h7 = h7; e.lat = lat;
        sb.push_back(e);
    endtask

    int          wcnt     = 0;
    bit          tracking = 0;
    int          cyc      = 0;
    int          rdy_leak = 0;
    int          done_cnt = 0;
    int unsigned ridx     = 0;
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];

    // Monitor: samples mid-cycle, measures latency from word-15 accept to done.
    always @(negedge clk) begin
        if (rst) begin
            wcnt = 0; tracking = 0; ridx = 0;
        end else begin
            if (cmp_enable && !cmp_update) begin
                if (ridx < 64) begin
                    cap_w[ridx] = cmp_w;
                    cap_k[ridx] = cmp_k;
                end
                ridx++;
            end else begin
                ridx = 0;
            end
            if (cmp_update) begin
                chk("upd_w_zero", cmp_w, 32'h0);
                chk("upd_k_zero", cmp_k, 32'h0);
                chk("upd_enable", {31'b0, cmp_enable}, 32'h1);
            end
            if (tracking) begin
                cyc++;
                if (s_ready) rdy_leak++;
            end
            if (done) begin
                done_cnt++;
                tracking = 0;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_latency"}, cyc, e.lat);
                    chk({e.name, "_ready_low"}, rdy_leak, 0);
                    chk({e.name, "_busy_at_done"}, {31'b0, busy}, 32'h1);
                    chk({e.name, "_enable_at_done"}, {31'b0, cmp_enable}, 32'h0);
                    if (e.chk_hash) begin
                        chk({e.name, "_H0"}, hs[0], e.h0);
                        chk({e.name, "_H7"}, hs[7], e.h7);
                    end
                end
            end
            if (s_valid && s_ready) begin
                if (wcnt == 15) begin
                    tracking = 1; cyc = 0; rdy_leak = 0;
                end
                wcnt = (wcnt + 1) % 16;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] blk [16];

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic send_word(input logic [31:0] d, input logic f, output bit ok);
        bit acc;
        int n;
        n = 0; ok = 0;
        s_data = d; s_first = f; s_valid = 1'b1;
        while (n < 500) begin
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) begin ok = 1; break; end
            n++;
        end
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic send_chunk(input string nm, input bit first, input bit gaps);
        bit ok;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            send_word(blk[i], (i == 0) ? first : 1'($urandom_range(0, 1)), ok);
            if (!ok) begin
                chk({nm, "_handshake"}, {31'b0, ok}, 32'h1);
                break;
            end
        end
    endtask

    task automatic wait_done(input string nm);
        int target;
        int n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < 400) begin @(posedge clk); #1; n++; end
        chk({nm, "_done_seen"}, {31'b0, done_cnt >= target}, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_s_ready"},    {31'b0, s_ready},    32'h1);
        chk({nm, "_busy"},       {31'b0, busy},       32'h0);
        chk({nm, "_done"},       {31'b0, done},       32'h0);
        chk({nm, "_cmp_rst_n"},  {31'b0, cmp_rst_n},  32'h0);
        chk({nm, "_cmp_enable"}, {31'b0, cmp_enable}, 32'h0);
        chk({nm, "_cmp_update"}, {31'b0, cmp_update}, 32'h0);
        chk({nm, "_cmp_w"},      cmp_w,               32'h0);
        chk({nm, "_cmp_k"},      cmp_k,               32'h428a2f98);
    endtask

    typedef struct {
        int unsigned round;
        bit          chk_w;
        logic [31:0] w;
        logic [31:0] k;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n;
        tbl[0] = '{0,  1'b1, 32'h61626380, 32'h428a2f98};
        tbl[1] = '{1,  1'b1, 32'h00000000, 32'h71374491};
        tbl[2] = '{14, 1'b1, 32'h00000000, 32'h9bdc06a7};
        tbl[3] = '{15, 1'b1, 32'h00000018, 32'hc19bf174};
        tbl[4] = '{16, 1'b1, 32'h61626380, 32'he49b69c1};
        tbl[5] = '{17, 1'b1, 32'h000f0000, 32'hefbe4786};
        tbl[6] = '{63, 1'b0, 32'h00000000, 32'hc67178f2};

        rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b0;
        #1 chk("por_rst_n_held", {31'b0, cmp_rst_n}, 32'h0);
        @(posedge clk); #1;
        chk("por_rst_n_release", {31'b0, cmp_rst_n}, 32'h1);

        // "abc" single chunk, then per-round W/K probes from the table.
        set_abc();
        push_exp("abc", 1'b1, 32'hba7816bf, 32'hf20015ad, 68);
        send_chunk("abc", 1'b1, 1'b0);
        wait_done("abc");
        foreach (tbl[i]) begin
            if (tbl[i].chk_w) chk($sformatf("abc_w_round%0d", tbl[i].round), cap_w[tbl[i].round], tbl[i].w);
            chk($sformatf("abc_k_round%0d", tbl[i].round), cap_k[tbl[i].round], tbl[i].k);
        end

        // "abc" with random input gaps.
        set_abc();
        push_exp("abc_gaps", 1'b1, 32'hba7816bf, 32'hf20015ad, 68);
        send_chunk("abc_gaps", 1'b1, 1'b1);
        wait_done("abc_gaps");

        // Two-chunk message; the second chunk must skip RSTC.
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        push_exp("two_c1", 1'b0, 32'h0, 32'h0, 68);
        send_chunk("two_c1", 1'b1, 1'b0);
        wait_done("two_c1");
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[15] = 32'h000001c0;
        push_exp("two_c2", 1'b1, 32'h248d6a61, 32'h19db06c1, 67);
        send_chunk("two_c2", 1'b0, 1'b0);
        wait_done("two_c2");

        // Back-to-back "abc" messages; RSTC must reinitialise H each time.
        set_abc();
        push_exp("b2b_1", 1'b1, 32'hba7816bf, 32'hf20015ad, 68);
        send_chunk("b2b_1", 1'b1, 1'b0);
        wait_done("b2b_1");
        push_exp("b2b_2", 1'b1, 32'hba7816bf, 32'hf20015ad, 68);
        send_chunk("b2b_2", 1'b1, 1'b0);
        wait_done("b2b_2");

        // Reset asserted around round 30, then a clean replay.
        send_chunk("abort", 1'b1, 1'b0);
        n = 0;
        while (ridx < 30 && n < 200) begin @(posedge clk); #1; n++; end
        chk("abort_reached_round30", {31'b0, ridx >= 30}, 32'h1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rst_n_release", {31'b0, cmp_rst_n}, 32'h1);
        push_exp("replay", 1'b1, 32'hba7816bf, 32'hf20015ad, 68);
        send_chunk("replay", 1'b1, 1'b0);
        wait_done("replay");

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
